pkt_assembler_mf: RTL and testbench
===================================

Name: pkt_assembler_mf

Overview:
- Parametrised successor of the event-to-packet assembler.
- Maps each incoming event word onto a SpiNNaker multicast packet.
- Each of NUM_FIELDS mapper fields is masked, shifted (signed) and limit-checked; the results are ORed into a base key.
- Out-of-limit events are dropped and counted. The block is a 2-stage valid/ready pipeline with an output skid buffer, at 1 event/cycle.
- Sits between the event input interface and the packet router.

Parameters:
- NUM_FIELDS, 4, number of mapper fields (1..8).
- EVT_BITS, 32, event word width (≤ 32).
- PKT_BITS, 72, output packet width: payload[71:40], key[39:8], header[7:0].
- CNT_BITS, 16, drop counter width.

Ports:
- clk_tb  in  1  clock.
- reset_tb  in  1  reset; asynchronous, active-high.
- mp_key_in  in  32  base routing key.
- mp_fld_msk_in  in  32 x NUM_FIELDS  per-field mask.
- mp_fld_sft_in  in  6 x NUM_FIELDS  per-field shift, two's complement; positive = right, negative = left.
- mp_fld_lmt_in  in  32 x NUM_FIELDS  per-field inclusive upper limit.
- evt_data_in  in  EVT_BITS  event word.
- evt_vld_in  in  1  event valid.
- evt_rdy_out  out  1  event ready.
- pkt_data_out  out  PKT_BITS  assembled packet.
- pkt_vld_out  out  1  packet valid.
- pkt_rdy_in  in  1  packet ready.
- drop_cnt_out  out  CNT_BITS  dropped-event count.
- drop_cnt_clr_in  in  1  synchronous clear of drop counter.

Behaviour:
- Clock and reset: clock clk_tb; reset reset_tb, asynchronous, active-high.
- Reset values: evt_rdy_out=0, pkt_vld_out=0, pkt_data_out=0, drop_cnt_out=0, all pipeline valids=0.
- evt_rdy_out goes 1 on the first clk_tb edge after reset release.

Handshake:
- Transfer occurs when vld & rdy on a rising edge.
- Once pkt_vld_out is asserted, pkt_data_out is held stable until accepted.

Stage 1 (S1), capture and field extraction, per field i:
- m_i = evt & msk_i (event zero-extended to 32 bits).
- v_i = m_i >> sft_i if sft_i ≥ 0; m_i << (−sft_i) if negative. Bits shifted out are lost. sft = −32 is legal and gives 0.
- out_i = (v_i > lmt_i).
- Config inputs are sampled on the S1 capture edge and are quasi-static otherwise.

Stage 2 (S2), assembly:
- key = mp_key | OR of all v_i.
- drop = OR of all out_i.
- If drop: no packet is produced; drop_cnt increments (saturating at all-ones).
- Otherwise: header[7:2]=0, header[1]=payload flag (see Optional Feature), header[0]=parity bit.
- Parity bit is chosen so the total 1-count of the 72-bit packet is odd.

Output buffer:
- 2-entry skid buffer; pkt_vld_out comes from the buffer head.

Latency and throughput:
- Event handshake at edge N → pkt_vld_out high after edge N+2 when no backpressure.
- Sustained 1 packet/cycle.

Backpressure:
- evt_rdy_out = S1 empty, or S1 able to advance this cycle.
- evt_rdy_out must depend on registered state only (no combinational path from pkt_rdy_in).
- No event is lost or reordered.
- Dropped events never occupy a buffer entry.

Drop counter:
- drop_cnt_clr_in wins over a simultaneous increment (result 0).
- Saturates; does not wrap.

Reset mid-operation:
- All in-flight events are discarded.
- Outputs return to reset values asynchronously.

Boundary cases:
- All masks zero → key = mp_key.
- lmt = 0xffff_ffff never drops.

Optional Feature:
- Macro: PKT_ASM_PAYLOAD_EN.
- Defined: the event is carried as payload; payload = evt zero-extended, header[1]=1.
- Undefined: payload = 0, header[1]=0, and payload logic is not synthesised.
- Parity covers all 72 bits in both cases.

Test Plan:
- Field mapping: key=0xee00_0000; msk0=0x00ff_0000, sft0=16; msk1=0x0000_00ff, sft1=−8; other fields mask 0, limits all 0xffff_ffff. Event 0x0012_0034 → key 0xee00_3412 two cycles after the event handshake; parity bit such that the packet 1-count is odd.
- Limit drop: as above with lmt0=0x10. Event 0x0012_0034 → no packet, drop_cnt_out=1. Event 0x0005_0001 → key 0xee00_0105 accepted. Pulsing drop_cnt_clr_in → 0.
- Backpressure: events 0,1,2,… driven continuously, pkt_rdy_in low for 10 cycles then high. Accepted events ≤ 4 while stalled; packets emerge in order with keys incrementing, no gaps or duplicates; data stable while stalled.
- Drop counter saturation: CNT_BITS=4, 20 out-of-limit events → drop_cnt_out sticks at 15. Clear asserted in the same cycle as a drop → 0.
- Reset mid-stream: reset_tb asserted with 3 packets in flight → pkt_vld_out low immediately. After release the first packet corresponds to the first post-reset event.
- PKT_ASM_PAYLOAD_EN: event 0xdead_beef with all masks 0 → payload 0xdead_beef, header[1]=1, key=mp_key. Without the macro → payload 0, header[1]=0.

Source files
------------

// File: rtl/pkt_assembler_mf.sv
`default_nettype none
// ============================================================================
// Module   : pkt_assembler_mf
// Purpose  : Maps event words onto SpiNNaker multicast packets. Each of
//            NUM_FIELDS mapper fields masks the event, shifts it (signed:
//            positive = right, negative = left) and checks it against an
//            inclusive upper limit. The shifted fields are ORed into a base
//            key. Events with any field over its limit are dropped and
//            counted. Two pipeline stages feed a 2-entry output skid buffer,
//            sustaining one event per cycle.
// Packet   : payload[71:40] | key[39:8] | header[7:0]
//            header[7:2]=0, header[1]=payload flag, header[0]=odd parity
//            over all 72 bits.
// Option   : define PKT_ASM_PAYLOAD_EN to carry the event as payload and set
//            header[1]; otherwise the payload is zero and no payload storage
//            is built.
// Ports    : clk_tb, reset_tb (async, active-high)
//            mp_key_in                 base routing key
//            mp_fld_msk/sft/lmt_in     per-field mask, shift, limit
//            evt_data/vld_in, evt_rdy_out     event input handshake
//            pkt_data/vld_out, pkt_rdy_in     packet output handshake
//            drop_cnt_out, drop_cnt_clr_in    saturating drop counter
// Revision : 1.0 - initial release
// ============================================================================
module pkt_assembler_mf #(
    parameter int NUM_FIELDS = 4,
    parameter int EVT_BITS   = 32,
    parameter int PKT_BITS   = 72,   // packet layout is fixed at 72 bits
    parameter int CNT_BITS   = 16
) (
    input  logic                        clk_tb,
    input  logic                        reset_tb,
    input  logic [31:0]                 mp_key_in,
    input  logic [NUM_FIELDS-1:0][31:0] mp_fld_msk_in,
    input  logic [NUM_FIELDS-1:0][5:0]  mp_fld_sft_in,
    input  logic [NUM_FIELDS-1:0][31:0] mp_fld_lmt_in,
    input  logic [EVT_BITS-1:0]         evt_data_in,
    input  logic                        evt_vld_in,
    output logic                        evt_rdy_out,
    output logic [PKT_BITS-1:0]         pkt_data_out,
    output logic                        pkt_vld_out,
    input  logic                        pkt_rdy_in,
    output logic [CNT_BITS-1:0]         drop_cnt_out,
    input  logic                        drop_cnt_clr_in
);

    // ------------------------------------------------------------------
    // Field extraction (evaluated on the S1 capture edge)
    // ------------------------------------------------------------------
    logic [31:0]                 w_evt32;
    logic [NUM_FIELDS-1:0][31:0] w_fld_v;
    logic [NUM_FIELDS-1:0]       w_fld_out;

    assign w_evt32 = 32'(evt_data_in);

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_fld
        logic [31:0] w_m;
        logic [5:0]  w_lsft;
        assign w_m    = w_evt32 & mp_fld_msk_in[gi];
        // Negated shift; -32 (6'b100000) negates to 32, which shifts
        // everything out and yields zero.
        assign w_lsft = 6'd0 - mp_fld_sft_in[gi];
        assign w_fld_v[gi]   = mp_fld_sft_in[gi][5] ? (w_m << w_lsft)
                                                    : (w_m >> mp_fld_sft_in[gi]);
        assign w_fld_out[gi] = (w_fld_v[gi] > mp_fld_lmt_in[gi]);
    end

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                        r_run;
    logic                        r_s1_vld;
    logic [31:0]                 r_s1_key;
    logic [NUM_FIELDS-1:0][31:0] r_s1_v;
    logic [NUM_FIELDS-1:0]       r_s1_out;
    logic                        r_s2_vld;
    logic                        r_s2_drop;
    logic [PKT_BITS-1:0]         r_s2_pkt;
    logic [PKT_BITS-1:0]         r_b0;     // buffer head
    logic [PKT_BITS-1:0]         r_b1;
    logic [1:0]                  r_cnt;
    logic [CNT_BITS-1:0]         r_drop_cnt;

    // ------------------------------------------------------------------
    // S2 assembly from the S1 registers
    // ------------------------------------------------------------------
    logic [31:0]         w_key;
    logic                w_drop;
    logic [31:0]         w_payload;
    logic                w_flag;
    logic [6:0]          w_hdr_hi;
    logic                w_parity;
    logic [PKT_BITS-1:0] w_pkt;

    always_comb begin
        w_key  = r_s1_key;
        w_drop = 1'b0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            w_key  = w_key | r_s1_v[i];
            w_drop = w_drop | r_s1_out[i];
        end
    end

`ifdef PKT_ASM_PAYLOAD_EN
    logic [31:0] r_s1_evt;

    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            r_s1_evt <= 32'd0;
        end else if (evt_vld_in && evt_rdy_out) begin
            r_s1_evt <= w_evt32;
        end
    end

    assign w_payload = r_s1_evt;
    assign w_flag    = 1'b1;
`else
    assign w_payload = 32'd0;
    assign w_flag    = 1'b0;
`endif

    assign w_hdr_hi = {6'd0, w_flag};
    // Parity set so the whole packet carries an odd number of ones.
    assign w_parity = ~(^{w_payload, w_key, w_hdr_hi});
    assign w_pkt    = {w_payload, w_key, w_hdr_hi, w_parity};

    // ------------------------------------------------------------------
    // Flow control: every term below comes from registers, so there is
    // no combinational path from pkt_rdy_in to evt_rdy_out. S2 only
    // advances into the buffer when a free entry already exists.
    // ------------------------------------------------------------------
    logic w_buf_space, w_s2_leave, w_s2_take, w_s1_leave;
    logic w_evt_hs, w_push, w_pop;

    assign w_buf_space = (r_cnt != 2'd2);
    assign w_s2_leave  = r_s2_vld & (r_s2_drop | w_buf_space);
    assign w_s2_take   = ~r_s2_vld | w_s2_leave;
    assign w_s1_leave  = r_s1_vld & w_s2_take;
    assign evt_rdy_out = r_run & (~r_s1_vld | w_s2_take);
    assign w_evt_hs    = evt_vld_in & evt_rdy_out;
    // Dropped events leave S2 without touching the buffer.
    assign w_push      = r_s2_vld & ~r_s2_drop & w_buf_space;
    assign w_pop       = pkt_vld_out & pkt_rdy_in;

    assign pkt_vld_out  = (r_cnt != 2'd0);
    assign pkt_data_out = r_b0;
    assign drop_cnt_out = r_drop_cnt;

    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            r_run      <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_key   <= 32'd0;
            r_s1_v     <= '0;
            r_s1_out   <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_drop  <= 1'b0;
            r_s2_pkt   <= '0;
            r_b0       <= '0;
            r_b1       <= '0;
            r_cnt      <= 2'd0;
            r_drop_cnt <= '0;
        end else begin
            r_run <= 1'b1;

            // S1: capture event, extracted fields and base key
            if (w_evt_hs) begin
                r_s1_vld <= 1'b1;
                r_s1_key <= mp_key_in;
                r_s1_v   <= w_fld_v;
                r_s1_out <= w_fld_out;
            end else if (w_s1_leave) begin
                r_s1_vld <= 1'b0;
            end

            // S2: assembled packet plus drop decision
            if (w_s1_leave) begin
                r_s2_vld  <= 1'b1;
                r_s2_pkt  <= w_pkt;
                r_s2_drop <= w_drop;
            end else if (w_s2_leave) begin
                r_s2_vld <= 1'b0;
            end

            // Drop counter: clear has priority, increment saturates
            if (drop_cnt_clr_in) begin
                r_drop_cnt <= '0;
            end else if (w_s2_leave && r_s2_drop && (r_drop_cnt != {CNT_BITS{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end

            // Skid buffer; a push always sees r_cnt < 2 and a pop r_cnt > 0
            case ({w_push, w_pop})
                2'b11: begin
                    r_b0 <= r_s2_pkt;
                end
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_b0 <= r_s2_pkt;
                    end else begin
                        r_b1 <= r_s2_pkt;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_b0  <= r_b1;
                    r_cnt <= r_cnt - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_assembler_mf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_assembler_mf
// Purpose  : Directed self-checking bench for pkt_assembler_mf (CNT_BITS=4).
//            Covers reset values, field mapping, limit drops, counter clear
//            and saturation, backpressure ordering, mid-stream reset and the
//            PKT_ASM_PAYLOAD_EN payload option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_assembler_mf;

    localparam int NF = 4;

`ifdef PKT_ASM_PAYLOAD_EN
    localparam logic [71:0] EXP_T1 = {32'h0012_0034, 32'hee00_3412, 8'h02};
    localparam logic [71:0] EXP_T2 = {32'h0005_0001, 32'hee00_0105, 8'h02};
    localparam logic [71:0] EXP_T6 = {32'hdead_beef, 32'h1234_5678, 8'h03};
`else
    localparam logic [71:0] EXP_T1 = {32'h0, 32'hee00_3412, 8'h00};
    localparam logic [71:0] EXP_T2 = {32'h0, 32'hee00_0105, 8'h00};
    localparam logic [71:0] EXP_T6 = {32'h0, 32'h1234_5678, 8'h00};
`endif

    logic                clk_tb = 1'b0;
    logic                reset_tb;
    logic [31:0]         mp_key_in;
    logic [NF-1:0][31:0] msk;
    logic [NF-1:0][5:0]  sft;
    logic [NF-1:0][31:0] lmt;
    logic [31:0]         evt_data_in;
    logic                evt_vld_in;
    logic                evt_rdy_out;
    logic [71:0]         pkt_data_out;
    logic                pkt_vld_out;
    logic                pkt_rdy_in;
    logic [3:0]          drop_cnt_out;
    logic                drop_cnt_clr_in;

    int n_tests = 0;
    int n_fail  = 0;
    logic [71:0] rx_q[$];

    always #5 clk_tb = ~clk_tb;

    pkt_assembler_mf #(
        .NUM_FIELDS(NF),
        .EVT_BITS  (32),
        .PKT_BITS  (72),
        .CNT_BITS  (4)
    ) u_dut (
        .clk_tb         (clk_tb),
        .reset_tb       (reset_tb),
        .mp_key_in      (mp_key_in),
        .mp_fld_msk_in  (msk),
        .mp_fld_sft_in  (sft),
        .mp_fld_lmt_in  (lmt),
        .evt_data_in    (evt_data_in),
        .evt_vld_in     (evt_vld_in),
        .evt_rdy_out    (evt_rdy_out),
        .pkt_data_out   (pkt_data_out),
        .pkt_vld_out    (pkt_vld_out),
        .pkt_rdy_in     (pkt_rdy_in),
        .drop_cnt_out   (drop_cnt_out),
        .drop_cnt_clr_in(drop_cnt_clr_in)
    );

    // Packets transferred at the coming rising edge
    always @(negedge clk_tb) begin
        if (!reset_tb && pkt_vld_out && pkt_rdy_in) rx_q.push_back(pkt_data_out);
    end

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    // Returns 1 ns after the handshake edge
    task automatic send_evt(input logic [31:0] d);
        logic ok;
        ok = 1'b0;
        evt_data_in = d;
        evt_vld_in  = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk_tb);
            if (evt_rdy_out) ok = 1'b1;
            @(posedge clk_tb);
            #1;
        end
        evt_vld_in = 1'b0;
        chk("evt_handshake", 72'(ok), 72'd1);
    endtask

    task automatic cfg_identity();
        mp_key_in = 32'h0;
        msk = '0; sft = '0; lmt = '1;
        msk[0] = 32'hffff_ffff;
        msk[1] = 32'hffff_ffff;
        sft[1] = 6'h20;             // shift -32: contributes nothing
    endtask

    initial begin : main
        logic        hs, have_hold;
        logic [71:0] hold;
        int          nxt, acc_stall;

        reset_tb = 1'b1; evt_vld_in = 1'b0; evt_data_in = '0;
        pkt_rdy_in = 1'b1; drop_cnt_clr_in = 1'b0;
        mp_key_in = '0; msk = '0; sft = '0; lmt = '1;

        // ---------------- reset values ----------------
        repeat (2) tick();
        chk("rst_evt_rdy",  72'(evt_rdy_out),  72'd0);
        chk("rst_pkt_vld",  72'(pkt_vld_out),  72'd0);
        chk("rst_pkt_data", pkt_data_out,      72'd0);
        chk("rst_drop_cnt", 72'(drop_cnt_out), 72'd0);
        #2 reset_tb = 1'b0;
        @(negedge clk_tb);
        chk("rdy_before_edge", 72'(evt_rdy_out), 72'd0);
        tick();
        chk("rdy_after_edge", 72'(evt_rdy_out), 72'd1);

        // ---------------- field mapping + latency ----------------
        mp_key_in = 32'hee00_0000;
        msk[0] = 32'h00ff_0000; sft[0] = 6'd16;
        msk[1] = 32'h0000_00ff; sft[1] = 6'h38;     // -8
        send_evt(32'h0012_0034);
        @(negedge clk_tb);
        @(negedge clk_tb);
        chk("t1_vld_n1", 72'(pkt_vld_out), 72'd0);
        @(negedge clk_tb);
        chk("t1_vld_n2", 72'(pkt_vld_out), 72'd1);
        chk("t1_pkt", pkt_data_out, EXP_T1);
        chk("t1_odd_ones", 72'($countones(pkt_data_out) % 2), 72'd1);
        repeat (2) tick();
        rx_q.delete();

        // ---------------- limit drop ----------------
        lmt[0] = 32'h10;
        send_evt(32'h0012_0034);
        repeat (5) tick();
        chk("t2_no_pkt", 72'(rx_q.size()), 72'd0);
        chk("t2_drop_cnt", 72'(drop_cnt_out), 72'd1);
        send_evt(32'h0005_0001);
        repeat (5) tick();
        chk("t2_pkt_cnt", 72'(rx_q.size()), 72'd1);
        if (rx_q.size() > 0) chk("t2_pkt", rx_q.pop_front(), EXP_T2);
        chk("t2_drop_hold", 72'(drop_cnt_out), 72'd1);
        drop_cnt_clr_in = 1'b1;
        tick();
        drop_cnt_clr_in = 1'b0;
        chk("t2_clr", 72'(drop_cnt_out), 72'd0);

        // ---------------- payload option, all masks zero ----------------
        msk = '0; sft = '0; lmt = '1;
        mp_key_in = 32'h1234_5678;
        rx_q.delete();
        send_evt(32'hdead_beef);
        repeat (4) tick();
        chk("t6_pkt_cnt", 72'(rx_q.size()), 72'd1);
        if (rx_q.size() > 0) chk("t6_pkt", rx_q.pop_front(), EXP_T6);

        // ---------------- backpressure ----------------
        cfg_identity();
        rx_q.delete();
        pkt_rdy_in = 1'b0; evt_vld_in = 1'b1; evt_data_in = 32'd0;
        nxt = 0; acc_stall = 0; have_hold = 1'b0; hold = '0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk_tb);
            hs = evt_vld_in && evt_rdy_out;
            if (!pkt_rdy_in && pkt_vld_out) begin
                if (have_hold) chk("t3_stable", pkt_data_out, hold);
                hold = pkt_data_out;
                have_hold = 1'b1;
            end
            @(posedge clk_tb);
            #1;
            if (hs) begin
                if (c < 10) acc_stall++;
                nxt++;
                evt_data_in = 32'(nxt);
                if (nxt == 20) evt_vld_in = 1'b0;
            end
            pkt_rdy_in = (c >= 9);
        end
        chk("t3_acc_stall_le4", 72'(acc_stall <= 4), 72'd1);
        chk("t3_rx_count", 72'(rx_q.size()), 72'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < rx_q.size()) chk($sformatf("t3_key%0d", i), 72'(rx_q[i][39:8]), 72'(i));
        end

        // ---------------- drop counter saturation ----------------
        rx_q.delete();
        mp_key_in = 32'hee00_0000;
        msk = '0; sft = '0; lmt = '1;
        msk[0] = 32'h00ff_0000; sft[0] = 6'd16; lmt[0] = 32'h10;
        evt_data_in = 32'h0012_0034;
        evt_vld_in  = 1'b1;
        repeat (20) tick();
        evt_vld_in = 1'b0;
        repeat (4) tick();
        chk("t4_sat", 72'(drop_cnt_out), 72'd15);
        chk("t4_no_pkt", 72'(rx_q.size()), 72'd0);
        // Clear coincides with an increment from the continuous drop stream
        evt_vld_in = 1'b1;
        repeat (3) tick();
        drop_cnt_clr_in = 1'b1;
        tick();
        drop_cnt_clr_in = 1'b0;
        chk("t4_clr_wins", 72'(drop_cnt_out), 72'd0);
        tick();
        chk("t4_after_clr", 72'(drop_cnt_out), 72'd1);
        evt_vld_in = 1'b0;
        repeat (5) tick();

        // ---------------- reset mid-stream ----------------
        cfg_identity();
        rx_q.delete();
        pkt_rdy_in = 1'b0;
        send_evt(32'd1);
        send_evt(32'd2);
        send_evt(32'd3);
        repeat (2) tick();
        chk("t5_vld_pre", 72'(pkt_vld_out), 72'd1);
        #2 reset_tb = 1'b1;
        #1;
        chk("t5_vld_async", 72'(pkt_vld_out), 72'd0);
        chk("t5_data_async", pkt_data_out, 72'd0);
        chk("t5_rdy_async", 72'(evt_rdy_out), 72'd0);
        chk("t5_cnt_async", 72'(drop_cnt_out), 72'd0);
        rx_q.delete();
        @(posedge clk_tb);
        #3 reset_tb = 1'b0;
        pkt_rdy_in = 1'b1;
        tick();
        send_evt(32'h77);
        repeat (5) tick();
        chk("t5_rx_count", 72'(rx_q.size()), 72'd1);
        if (rx_q.size() > 0) chk("t5_first_key", 72'(rx_q[0][39:8]), 72'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
